// File: rtl/wb_arbiter.sv
// Writeback arbiter: three result FIFOs (ALU/LSU/BR) merged round-robin into one registered CDB port.
// Optional macro WB_ARB_BR_PRIO_EN lets a mispredicted branch at the BR FIFO head bypass round-robin.
package wb_arbiter_pkg;
  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_val;
    logic        completed;
    logic [5:0]  ROB_tag;
  } alu_out_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_val;
    logic        completed;
    logic [5:0]  ROB_tag;
  } lsu_out_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_val;
    logic        completed;
    logic [5:0]  ROB_tag;
    logic        mispredict;
    logic        branch_taken;
    logic [31:0] dest_addr;
  } branch_out_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_val;
    logic        completed;
    logic [5:0]  ROB_tag;
    logic        mispredict;
    logic        branch_taken;
    logic [31:0] dest_addr;
    logic [1:0]  src_fu;
  } wb_packet_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  alu_out_t    alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  lsu_out_t    lsu_data,
  input  logic        br_valid,
  output logic        br_ready,
  input  branch_out_t br_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output wb_packet_t  wb_pkt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  function automatic wb_packet_t map_alu(input alu_out_t a);
    wb_packet_t p;
    p           = '0;
    p.rd_addr   = a.rd_addr;
    p.rd_val    = a.rd_val;
    p.completed = a.completed;
    p.ROB_tag   = a.ROB_tag;
    p.src_fu    = 2'd0;
    return p;
  endfunction

  function automatic wb_packet_t map_lsu(input lsu_out_t a);
    wb_packet_t p;
    p           = '0;
    p.rd_addr   = a.rd_addr;
    p.rd_val    = a.rd_val;
    p.completed = a.completed;
    p.ROB_tag   = a.ROB_tag;
    p.src_fu    = 2'd1;
    return p;
  endfunction

  function automatic wb_packet_t map_br(input branch_out_t a);
    wb_packet_t p;
    p              = '0;
    p.rd_addr      = a.rd_addr;
    p.rd_val       = a.rd_val;
    p.completed    = a.completed;
    p.ROB_tag      = a.ROB_tag;
    p.mispredict   = a.mispredict;
    p.branch_taken = a.branch_taken;
    p.dest_addr    = a.dest_addr;
    p.src_fu       = 2'd2;
    return p;
  endfunction

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  wb_packet_t       in_pkt [3];
  logic [2:0]       in_valid;
  wb_packet_t       mem_q  [3][DEPTH];
  logic [CW-1:0]    cnt_q  [3];
  logic [CW-1:0]    cnt_d  [3];
  logic [PW-1:0]    wr_q   [3];
  logic [PW-1:0]    wr_d   [3];
  logic [PW-1:0]    rd_q   [3];
  logic [PW-1:0]    rd_d   [3];
  logic [1:0]       rr_q, rr_d;
  logic             wb_valid_q, wb_valid_d;
  wb_packet_t       wb_pkt_q, wb_pkt_d;
  logic [2:0]       ready, nonempty, push, pop;
  logic             load, found, prio;
  logic [1:0]       grant, cand;

  assign in_valid  = {br_valid, lsu_valid, alu_valid};
  assign alu_ready = ready[0];
  assign lsu_ready = ready[1];
  assign br_ready  = ready[2];
  assign wb_valid  = wb_valid_q;
  assign wb_pkt    = wb_pkt_q;

  always_comb begin
    in_pkt[0] = map_alu(alu_data);
    in_pkt[1] = map_lsu(lsu_data);
    in_pkt[2] = map_br(br_data);
    for (int s = 0; s < 3; s++) begin
      ready[s]    = cnt_q[s] < CW'(DEPTH);
      nonempty[s] = cnt_q[s] != '0;
    end
  end

  // Grant: first non-empty FIFO from rr_q, optionally overridden by a mispredicted branch head
  always_comb begin
    found = 1'b0;
    grant = 2'd0;
    prio  = 1'b0;
    cand  = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!found && nonempty[cand]) begin
        found = 1'b1;
        grant = cand;
      end
      cand = next_src(cand);
    end
`ifdef WB_ARB_BR_PRIO_EN
    if (nonempty[2] && mem_q[2][rd_q[2]].mispredict) begin
      found = 1'b1;
      grant = 2'd2;
      prio  = 1'b1;
    end
`else
    prio = 1'b0;
`endif
  end

  always_comb begin
    load       = !wb_valid_q || wb_ready;
    pop        = '0;
    push       = in_valid & ready;
    wb_valid_d = wb_valid_q;
    wb_pkt_d   = wb_pkt_q;
    rr_d       = rr_q;
    if (load) begin
      wb_valid_d = found;
      if (found) begin
        wb_pkt_d   = mem_q[grant][rd_q[grant]];
        pop[grant] = 1'b1;
        rr_d       = prio ? 2'd0 : next_src(grant);
      end
    end
    if (flush) begin
      push       = '0;
      pop        = '0;
      wb_valid_d = 1'b0;
      rr_d       = rr_q;
    end
    for (int s = 0; s < 3; s++) begin
      cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      wr_d[s]  = wr_q[s] + PW'(push[s]);
      rd_d[s]  = rd_q[s] + PW'(pop[s]);
      if (flush) begin
        cnt_d[s] = '0;
        wr_d[s]  = '0;
        rd_d[s]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        cnt_q[s] <= '0;
        wr_q[s]  <= '0;
        rd_q[s]  <= '0;
      end
      rr_q       <= 2'd0;
      wb_valid_q <= 1'b0;
      wb_pkt_q   <= '0;
    end else begin
      for (int s = 0; s < 3; s++) begin
        cnt_q[s] <= cnt_d[s];
        wr_q[s]  <= wr_d[s];
        rd_q[s]  <= rd_d[s];
      end
      rr_q       <= rr_d;
      wb_valid_q <= wb_valid_d;
      wb_pkt_q   <= wb_pkt_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the counters clear
  always_ff @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (push[s]) mem_q[s][wr_q[s]] <= in_pkt[s];
    end
  end
endmodule
